gcd_seq_ctrl: RTL
=================

# gcd_seq_ctrl

Sequencer for the 16-bit subtractive GCD datapath: the A/B load registers, the two operand muxes, the load-bus mux, the subtractor and the comparator. It accepts a start request and steers two operands from `data_in` into A and B. It then iterates subtract-and-compare until the datapath reports equality or a zero operand short-circuits the loop, and signals done/error with a result-select flag. It replaces the latch-prone, delay-based controller: outputs are a pure Moore decode of the state register, and the block contains no `#` delays.

## Interface
- `W`, 16, operand width; used only for zero detection on `data_in`.
- `MAX_ITER`, 65535, subtraction limit before error; used only with the timeout feature.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request; sampled in IDLE or DONE.
- `data_in` in W: operand bus, the same net driving the datapath load mux; used for zero detection.
- `lt`, `gt`, `eq` in 1 each: datapath comparator outputs for A versus B.
- `ldA`, `ldB` out 1 each: register load enables.
- `sel1`, `sel2` out 1 each: subtractor operand selects (0 = A, 1 = B).
- `sel_in` out 1: load-bus select (1 = `data_in`, 0 = subtractor).
- `ready` out 1: idle, accepting `start`.
- `busy` out 1: operation in progress.
- `done` out 1: result valid; level signal.
- `res_sel` out 1: result is in A (0) or in B (1).
- `error` out 1: timeout or inconsistent comparator flags.

## Operation
- **States:** IDLE, LOADA, LOADB, CMP, SUBA, SUBB, DONE, ERR.
- **Moore outputs:** decoded from state only.
  - LOADA: `sel_in`=1, `ldA`=1.
  - LOADB: `sel_in`=1, `ldB`=1.
  - SUBA: `sel1`=0, `sel2`=1, `sel_in`=0, `ldA`=1 (A ← A−B).
  - SUBB: `sel1`=1, `sel2`=0, `sel_in`=0, `ldB`=1 (B ← B−A).
  - All other states drive all of these low.
- **Status outputs:**
  - `ready` = IDLE or DONE or ERR.
  - `busy` = not `ready`.
  - `done` = DONE or ERR.
  - `error` = ERR.
- **IDLE/DONE/ERR:** `start`=1 moves to LOADA. Otherwise the state holds.
- **Operand sequencing:** the parent drives operand A on `data_in` during LOADA and operand B during LOADB. It may use `ldA`/`ldB` as operand strobes.
- **LOADA:** register `a_zero` = (`data_in`==0), then move to LOADB.
- **LOADB:** b_zero = (`data_in`==0), evaluated combinationally.
  - If `a_zero` or b_zero, move to DONE.
  - Otherwise move to CMP.
- **CMP priority:**
  - `eq` → DONE.
  - else `lt` → SUBB.
  - else `gt` → SUBA.
  - no flag set → ERR.
- **SUBA/SUBB:** return to CMP.
- **`res_sel` register:**
  - Cleared on entry to LOADA.
  - Set on LOADB→DONE when `a_zero` is set and b_zero is clear.
  - Otherwise 0 (result in A; equal case, B=0 case, and 0/0 → result 0).
- **Reset, whether idle or mid-operation:** state goes to IDLE, `res_sel`, `a_zero` and the counter clear, and no register load is issued during or after reset.

## Timing
- **Reset values:**
  - `ldA`, `ldB`, `sel1`, `sel2`, `sel_in`, `busy`, `done`, `error`, `res_sel` = 0.
  - `ready` = 1.
- **Comparator validity:** `lt`/`gt`/`eq` are valid in CMP because A/B were loaded on the prior edge.
- **Normal latency:** with k subtractions, `done` rises at the (2k+4)th rising edge, counting the edge that samples `start` as the first.
- **Zero short-circuit latency:** `done` rises at the 3rd edge.
- **Back-to-back:** `start` held in DONE restarts at the next edge. `done` drops in the same edge that enters LOADA.

## Configuration
- **`GCD_CTRL_TIMEOUT_EN` defined:**
  - A 16-bit iteration counter clears on LOADA and increments on each SUBA/SUBB entry.
  - In CMP, with `eq`=0 and count==`MAX_ITER`, the next state is ERR.
- **`GCD_CTRL_TIMEOUT_EN` undefined:**
  - No counter is built.
  - ERR is reachable only through the no-flag condition.

## Structure
- **Shared package `gcd_pkg`:** state enum, `W` default, mux select constants (`SEL_A`=0, `SEL_B`=1, `BUS_SUB`=0, `BUS_DIN`=1).
- **Sub-module `gcd_iter_cnt`:** instantiated only under `GCD_CTRL_TIMEOUT_EN`. Inputs: `clk`, `rst_n`, clear, inc. Outputs: count and limit-hit.

## Test plan
- **gcd(12,18):** `start`, A=12, B=18 → sequence SUBB, SUBA. `done` at edge 8 with A=B=6, `res_sel`=0, `error`=0.
- **gcd(7,7):** → `done` at edge 4, no `ldA`/`ldB` pulses after LOADB.
- **gcd(0,9):** → `done` at edge 3, `res_sel`=1, B=9. gcd(9,0) → `res_sel`=0.
- **Timeout:** with `GCD_CTRL_TIMEOUT_EN` and `MAX_ITER`=4, gcd(1,10) → ERR at edge 12, `error`=1 and `done`=1. Without the macro, `done` occurs at edge 22 with result 1.
- **Reset mid-operation:** `rst_n` low during SUBB → all outputs immediately reach reset values and `ready`=1. A new gcd(15,25) afterwards → result 5.
- **Forced comparator fault:** `lt`=`gt`=`eq`=0 in CMP → ERR next edge. `start` then recovers into LOADA.

Source files
------------

// File: rtl/gcd_seq_ctrl_pkg.sv
// Shared types and constants for the subtractive GCD sequencer and its datapath.
package gcd_pkg;

  localparam int W_DEF = 16;
  localparam int CNT_W = 16;

  // Operand-mux and load-bus select encodings seen by the datapath.
  localparam logic SEL_A   = 1'b0;
  localparam logic SEL_B   = 1'b1;
  localparam logic BUS_SUB = 1'b0;
  localparam logic BUS_DIN = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOADA,
    ST_LOADB,
    ST_CMP,
    ST_SUBA,
    ST_SUBB,
    ST_DONE,
    ST_ERR
  } state_e;

endpackage

// File: rtl/gcd_seq_ctrl_if.sv
// Handshake and datapath-control bundle between the GCD sequencer (slave) and its parent (master).
interface gcd_seq_ctrl_if #(
  parameter int W = 16
);
  logic         start;
  logic [W-1:0] data_in;
  logic         lt;
  logic         gt;
  logic         eq;
  logic         ldA;
  logic         ldB;
  logic         sel1;
  logic         sel2;
  logic         sel_in;
  logic         ready;
  logic         busy;
  logic         done;
  logic         res_sel;
  logic         error;

  modport master (
    output start, data_in, lt, gt, eq,
    input  ldA, ldB, sel1, sel2, sel_in, ready, busy, done, res_sel, error
  );

  modport slave (
    input  start, data_in, lt, gt, eq,
    output ldA, ldB, sel1, sel2, sel_in, ready, busy, done, res_sel, error
  );
endinterface

// File: rtl/gcd_seq_ctrl_iter_cnt.sv
// Subtraction counter for the GCD sequencer timeout; built only with GCD_CTRL_TIMEOUT_EN.
module gcd_iter_cnt
  import gcd_pkg::*;
#(
  parameter int MAX_ITER = 65535
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o,
  output logic             limit_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign limit_o = (count_q == CNT_W'(MAX_ITER));

endmodule

// File: rtl/gcd_seq_ctrl.sv
// Moore sequencer for the 16-bit subtractive GCD datapath.
// Optional iteration timeout enabled by defining GCD_CTRL_TIMEOUT_EN.
module gcd_seq_ctrl
  import gcd_pkg::*;
#(
  parameter int W = W_DEF
`ifdef GCD_CTRL_TIMEOUT_EN
  , parameter int MAX_ITER = 65535
`endif
) (
  input  logic          clk,
  input  logic          rst_n,
  gcd_seq_ctrl_if.slave bus
);

  state_e state_q;
  state_e state_d;
  logic   a_zero_q;
  logic   a_zero_d;
  logic   res_sel_q;
  logic   res_sel_d;
  logic   din_zero;
  logic   limit_hit;

  assign din_zero = (bus.data_in == {W{1'b0}});

`ifdef GCD_CTRL_TIMEOUT_EN
  logic [CNT_W-1:0] iter_cnt;
  logic             cnt_clr;
  logic             cnt_inc;

  assign cnt_clr = (state_q == ST_LOADA);
  assign cnt_inc = (state_d == ST_SUBA) || (state_d == ST_SUBB);

  gcd_iter_cnt #(
    .MAX_ITER (MAX_ITER)
  ) u_iter_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (cnt_clr),
    .inc_i   (cnt_inc),
    .count_o (iter_cnt),
    .limit_o (limit_hit)
  );
`else
  assign limit_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    a_zero_d  = a_zero_q;
    res_sel_d = res_sel_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (bus.start) begin
          state_d   = ST_LOADA;
          res_sel_d = 1'b0;
        end
      end
      ST_LOADA: begin
        a_zero_d = din_zero;
        state_d  = ST_LOADB;
      end
      ST_LOADB: begin
        // Any zero operand already determines the answer: the other operand.
        if (a_zero_q || din_zero) begin
          state_d   = ST_DONE;
          res_sel_d = a_zero_q && !din_zero;
        end else begin
          state_d = ST_CMP;
        end
      end
      ST_CMP: begin
        if (bus.eq) begin
          state_d = ST_DONE;
        end else if (limit_hit) begin
          state_d = ST_ERR;
        end else if (bus.lt) begin
          state_d = ST_SUBB;
        end else if (bus.gt) begin
          state_d = ST_SUBA;
        end else begin
          state_d = ST_ERR;
        end
      end
      ST_SUBA, ST_SUBB: begin
        state_d = ST_CMP;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      a_zero_q  <= 1'b0;
      res_sel_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_zero_q  <= a_zero_d;
      res_sel_q <= res_sel_d;
    end
  end

  logic ld_a;
  logic ld_b;
  logic sel1;
  logic sel2;
  logic sel_in;

  always_comb begin
    ld_a   = 1'b0;
    ld_b   = 1'b0;
    sel1   = SEL_A;
    sel2   = SEL_A;
    sel_in = BUS_SUB;
    case (state_q)
      ST_LOADA: begin
        sel_in = BUS_DIN;
        ld_a   = 1'b1;
      end
      ST_LOADB: begin
        sel_in = BUS_DIN;
        ld_b   = 1'b1;
      end
      ST_SUBA: begin
        sel1   = SEL_A;
        sel2   = SEL_B;
        sel_in = BUS_SUB;
        ld_a   = 1'b1;
      end
      ST_SUBB: begin
        sel1   = SEL_B;
        sel2   = SEL_A;
        sel_in = BUS_SUB;
        ld_b   = 1'b1;
      end
      default: begin
        ld_a = 1'b0;
      end
    endcase
  end

  assign bus.ldA     = ld_a;
  assign bus.ldB     = ld_b;
  assign bus.sel1    = sel1;
  assign bus.sel2    = sel2;
  assign bus.sel_in  = sel_in;
  assign bus.ready   = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR);
  assign bus.busy    = !bus.ready;
  assign bus.done    = (state_q == ST_DONE) || (state_q == ST_ERR);
  assign bus.error   = (state_q == ST_ERR);
  assign bus.res_sel = res_sel_q;

endmodule
